load_store_unit: RTL and testbench

- Executes the memory-access half of the single-stage RV32I core.
- Consumes the decoder's is_load/is_store codes, the ALU effective address and rs2 data.
- Drives a request/grant/response data-memory port: byte-lane strobes, store-data replication, load extraction with sign/zero extension.
- Stalls the core while an access is outstanding.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings for the RV32I core memory stage: load/store
//            codes, byte-strobe constants and the LSU state type.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Load codes produced by the decoder
    localparam logic [2:0] LOAD_DISABLE = 3'd0;
    localparam logic [2:0] LOAD_LB      = 3'd1;
    localparam logic [2:0] LOAD_LH      = 3'd2;
    localparam logic [2:0] LOAD_LW      = 3'd3;
    localparam logic [2:0] LOAD_LBU     = 3'd4;
    localparam logic [2:0] LOAD_LHU     = 3'd5;

    // Store codes produced by the decoder
    localparam logic [1:0] STORE_DISABLE = 2'd0;
    localparam logic [1:0] STORE_SB      = 2'd1;
    localparam logic [1:0] STORE_SH      = 2'd2;
    localparam logic [1:0] STORE_SW      = 2'd3;

    // Byte-lane strobe patterns
    localparam logic [3:0] WSTRB_NONE    = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE0   = 4'b0001;
    localparam logic [3:0] WSTRB_LO_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_HI_HALF = 4'b1100;
    localparam logic [3:0] WSTRB_ALL     = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    // Alignment rule: halfwords need addr[0]==0, words need addr[1:0]==0.
    // The store code passed in must already have load priority applied.
    function automatic logic access_misaligned(input logic [2:0] load_code,
                                               input logic [1:0] store_code,
                                               input logic [1:0] addr_lo);
        logic half;
        logic word;
        half = (load_code == LOAD_LH) || (load_code == LOAD_LHU) ||
               (store_code == STORE_SH);
        word = (load_code == LOAD_LW) || (store_code == STORE_SW);
        return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational byte-lane logic: store strobes and data
//            replication, load byte/halfword extraction and extension.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import cpu_pkg::*;
(
    input  logic [2:0]  load_code,
    input  logic [1:0]  store_code,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: lane enables and data replicated across all lanes
    always_comb begin
        wstrb = WSTRB_NONE;
        wdata = 32'h0;
        case (store_code)
            STORE_SB: begin
                wstrb = WSTRB_BYTE0 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            STORE_SH: begin
                wstrb = addr_lo[1] ? WSTRB_HI_HALF : WSTRB_LO_HALF;
                wdata = {2{store_data[15:0]}};
            end
            STORE_SW: begin
                wstrb = WSTRB_ALL;
                wdata = store_data;
            end
            default: begin
                wstrb = WSTRB_NONE;
                wdata = 32'h0;
            end
        endcase
    end

    // Load side: pick the addressed lane(s) and sign/zero extend
    always_comb begin
        w_byte   = rdata[{addr_lo, 3'b000} +: 8];
        w_half   = rdata[{addr_lo[1], 4'b0000} +: 16];
        load_ext = 32'h0;
        case (load_code)
            LOAD_LB:  load_ext = {{24{w_byte[7]}}, w_byte};
            LOAD_LH:  load_ext = {{16{w_half[15]}}, w_half};
            LOAD_LW:  load_ext = rdata;
            LOAD_LBU: load_ext = {24'h0, w_byte};
            LOAD_LHU: load_ext = {16'h0, w_half};
            default:  load_ext = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Memory-access stage of the single-stage RV32I core. Captures a
//            load/store, drives a req/gnt/rvalid data port, stalls the core
//            until the access resolves and returns the extended load value.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  is_load,
    input  logic [1:0]  is_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // The counter holds completed WAIT_R cycles; the cycle in which it would
    // step to TIMEOUT-1 is the last one in which rvalid is still accepted.
    localparam logic [7:0] C_COUNT_LAST = 8'(TIMEOUT - 2);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;

    logic [2:0]  r_load_code;
    logic [1:0]  r_store_code;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_rdata;
    logic        r_misaligned;
    logic        r_bus_err;
    logic [7:0]  r_count;

    logic        w_access;
    logic [1:0]  w_in_store;
    logic        w_in_misaligned;
    logic        w_capture;
    logic        w_take_rdata;
    logic        w_timeout;
    logic        w_count_clr;
    logic        w_count_inc;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_ext;

    assign w_access        = (is_load != LOAD_DISABLE) || (is_store != STORE_DISABLE);
    // A simultaneous load and store is illegal; the load wins.
    assign w_in_store      = (is_load != LOAD_DISABLE) ? STORE_DISABLE : is_store;
    assign w_in_misaligned = access_misaligned(is_load, w_in_store, addr[1:0]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus handshake and datapath control strobes
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_take_rdata = 1'b0;
        w_timeout    = 1'b0;
        w_count_clr  = 1'b0;
        w_count_inc  = 1'b0;
        stall        = 1'b0;
        done         = 1'b0;
        mem_req      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_access && rst_n) begin
                    stall        = 1'b1;
                    w_capture    = 1'b1;
                    w_next_state = w_in_misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_gnt) begin
                    if (r_store_code != STORE_DISABLE) begin
                        w_next_state = RESP;
                    end else if (mem_rvalid) begin
                        w_take_rdata = 1'b1;
                        w_next_state = RESP;
                    end else begin
                        w_count_clr  = 1'b1;
                        w_next_state = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                stall = 1'b1;
                if (mem_rvalid) begin
                    w_take_rdata = 1'b1;
                    w_next_state = RESP;
                end else if (r_count == C_COUNT_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_count_inc = 1'b1;
                end
            end
            RESP: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Captured access, read data, result flags and rvalid timeout counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_load_code  <= LOAD_DISABLE;
            r_store_code <= STORE_DISABLE;
            r_addr       <= 32'h0;
            r_store_data <= 32'h0;
            r_rdata      <= 32'h0;
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
            r_count      <= 8'h0;
        end else begin
            if (w_capture) begin
                r_load_code  <= is_load;
                r_store_code <= w_in_store;
                r_addr       <= addr;
                r_store_data <= store_data;
                r_rdata      <= 32'h0;
                r_misaligned <= w_in_misaligned;
                r_bus_err    <= 1'b0;
            end
            if (w_take_rdata) begin
                r_rdata <= mem_rdata;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
            if (w_count_clr) begin
                r_count <= 8'h0;
            end else if (w_count_inc) begin
                r_count <= r_count + 8'h1;
            end
        end
    end

    lsu_align u_align (
        .load_code  (r_load_code),
        .store_code (r_store_code),
        .addr_lo    (r_addr[1:0]),
        .store_data (r_store_data),
        .rdata      (r_rdata),
        .wstrb      (w_wstrb),
        .wdata      (w_wdata),
        .load_ext   (w_load_ext)
    );

    // Memory port is driven only from captured registers and only in REQ,
    // so it stays stable while waiting for grant and is zero otherwise.
    assign mem_we    = mem_req && (r_store_code != STORE_DISABLE);
    assign mem_addr  = mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
    assign mem_wstrb = mem_req ? w_wstrb : WSTRB_NONE;
    assign mem_wdata = mem_req ? w_wdata : 32'h0;

    assign misaligned = done && r_misaligned;
    assign bus_err    = done && r_bus_err;
    assign load_data  = (done && (r_load_code != LOAD_DISABLE) && !r_misaligned && !r_bus_err)
                        ? w_load_ext : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit: directed corner cases
//            followed by randomized accesses against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;
    import cpu_pkg::*;

    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  is_load;
    logic [1:0]  is_store;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .is_load    (is_load),
        .is_store   (is_store),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .done       (done),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        is_load    = LOAD_DISABLE;
        is_store   = STORE_DISABLE;
        addr       = 32'h0;
        store_data = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_mis"}, misaligned, 0);
        check({tag, "_berr"}, bus_err, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_strb"}, mem_wstrb, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_ldata"}, load_data, 0);
    endtask

    // One complete access. gnt_dly: REQ cycles without grant before the grant.
    // rv_dly: cycle (relative to the grant cycle) in which rvalid is driven;
    // negative means never. Called just after a rising edge.
    task automatic do_access(input logic [2:0] lc, input logic [1:0] sc,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int gnt_dly, input int rv_dly, input logic [31:0] rd);
        bit          ld;
        int          size;
        bit          sgn;
        bit          mis;
        bit          berr;
        int          done_cyc;
        logic [31:0] exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] shifted;
        logic [31:0] val;
        logic [31:0] exp_ld;

        // Reference model from the access rules
        ld   = (lc != LOAD_DISABLE);
        sgn  = (lc == LOAD_LB) || (lc == LOAD_LH);
        if (ld) size = (lc == LOAD_LW) ? 4 : ((lc == LOAD_LH || lc == LOAD_LHU) ? 2 : 1);
        else    size = (sc == STORE_SW) ? 4 : ((sc == STORE_SH) ? 2 : 1);
        mis = ((a % size) != 0);
        if (ld) begin
            exp_strb  = 0;
            exp_wdata = 0;
        end else if (size == 1) begin
            exp_strb  = 1 << (a % 4);
            exp_wdata = (sd & 32'hFF) * 32'h0101_0101;
        end else if (size == 2) begin
            exp_strb  = 3 << (a % 4);
            exp_wdata = (sd & 32'hFFFF) * 32'h0001_0001;
        end else begin
            exp_strb  = 15;
            exp_wdata = sd;
        end
        berr     = ld && !(rv_dly >= 0 && rv_dly <= TO - 1);
        done_cyc = !ld ? 1 : (berr ? TO : rv_dly + 1);
        shifted  = rd >> (8 * (a % 4));
        if (size == 1) begin
            val = shifted & 32'hFF;
            if (sgn && val >= 128) val = val - 256;
        end else if (size == 2) begin
            val = shifted & 32'hFFFF;
            if (sgn && val >= 32768) val = val - 65536;
        end else begin
            val = rd;
        end
        exp_ld = (ld && !mis && !berr) ? val : 32'h0;

        is_load    = lc;
        is_store   = sc;
        addr       = a;
        store_data = sd;
        @(negedge clk);
        check("cap_stall", stall, 1);
        check("cap_req", mem_req, 0);
        check("cap_done", done, 0);
        tick();

        if (mis) begin
            @(negedge clk);
            check("mis_done", done, 1);
            check("mis_flag", misaligned, 1);
            check("mis_berr", bus_err, 0);
            check("mis_ldata", load_data, 0);
            check("mis_req", mem_req, 0);
            check("mis_stall", stall, 0);
            tick();
            clear_inputs();
            return;
        end

        for (int k = 0; k <= gnt_dly; k++) begin
            mem_gnt = (k == gnt_dly);
            if (k == gnt_dly && ld && rv_dly == 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            @(negedge clk);
            check("req_req", mem_req, 1);
            check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
            check("req_we", mem_we, !ld);
            check("req_strb", mem_wstrb, exp_strb);
            check("req_wdata", mem_wdata, exp_wdata);
            check("req_stall", stall, 1);
            check("req_done", done, 0);
            tick();
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end

        for (int j = 1; j <= done_cyc; j++) begin
            if (ld && j == rv_dly) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd;
            end
            @(negedge clk);
            if (j < done_cyc) begin
                check("wait_stall", stall, 1);
                check("wait_done", done, 0);
                check("wait_req", mem_req, 0);
            end else begin
                check("resp_done", done, 1);
                check("resp_mis", misaligned, 0);
                check("resp_berr", bus_err, berr);
                check("resp_ldata", load_data, exp_ld);
                check("resp_stall", stall, 0);
                check("resp_req", mem_req, 0);
            end
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
        end
        clear_inputs();
    endtask

    initial begin
        logic [2:0]  lc;
        logic [1:0]  sc;

        rst_n      = 1'b0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        check_all_zero("rst");
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");
        tick();

        // Directed corner cases
        do_access(LOAD_DISABLE, STORE_SB, 32'h0000_1003, 32'h0000_00A5, 1, -1, 32'h0);
        do_access(LOAD_LB,  STORE_DISABLE, 32'h0000_2001, 32'h0, 0, 2, 32'h0000_8000);
        do_access(LOAD_LBU, STORE_DISABLE, 32'h0000_2001, 32'h0, 0, 2, 32'h0000_8000);
        do_access(LOAD_LHU, STORE_DISABLE, 32'h0000_2002, 32'h0, 0, 1, 32'hBEEF_0000);
        do_access(LOAD_LH,  STORE_DISABLE, 32'h0000_2002, 32'h0, 1, 1, 32'hBEEF_0000);
        do_access(LOAD_LW,  STORE_DISABLE, 32'h0000_3002, 32'h0, 0, 0, 32'h0);
        do_access(LOAD_DISABLE, STORE_SH, 32'h0000_3001, 32'h1234, 0, -1, 32'h0);
        do_access(LOAD_LW,  STORE_DISABLE, 32'h0000_5000, 32'h0, 5, 0, 32'h1234_5678);
        do_access(LOAD_LW,  STORE_DISABLE, 32'h0000_6000, 32'h0, 0, -1, 32'hCAFE_F00D);
        do_access(LOAD_LW,  STORE_DISABLE, 32'h0000_6004, 32'h0, 0, TO - 1, 32'hCAFE_F00D);
        do_access(LOAD_LW,  STORE_DISABLE, 32'h0000_6008, 32'h0, 0, TO, 32'hCAFE_F00D);
        do_access(LOAD_DISABLE, STORE_SH, 32'h0000_7002, 32'hAAAA_5A5A, 2, -1, 32'h0);
        do_access(LOAD_DISABLE, STORE_SW, 32'h0000_7004, 32'hDEAD_BEEF, 0, -1, 32'h0);
        do_access(LOAD_LH,  STORE_SW, 32'h0000_7006, 32'h1111_2222, 0, 1, 32'h8001_7FFF);

        // Reset in the middle of WAIT_R
        is_load = LOAD_LW;
        addr    = 32'h0000_4000;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        tick();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        @(negedge clk);
        check_all_zero("midrst");
        tick();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        @(negedge clk);
        check("late_rv_done", done, 0);
        check("late_rv_stall", stall, 0);
        tick();
        mem_rvalid = 1'b0;
        @(negedge clk);
        check("late_rv_done2", done, 0);
        check("late_rv_req", mem_req, 0);
        tick();
        do_access(LOAD_DISABLE, STORE_SW, 32'h0000_8000, 32'h0BAD_F00D, 1, -1, 32'h0);

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            lc = LOAD_DISABLE;
            sc = STORE_DISABLE;
            if ($urandom_range(0, 1) == 1) lc = 3'($urandom_range(1, 5));
            if (lc == LOAD_DISABLE || $urandom_range(0, 7) == 0) sc = 2'($urandom_range(1, 3));
            do_access(lc, sc, $urandom, $urandom, $urandom_range(0, 3),
                      int'($urandom_range(0, TO + 2)) - 1, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
